// File: rtl/gpu_mem_pkg.sv
// Shared definitions for the VRAM burst-writer packing stages.
package gpu_mem_pkg;

    localparam int PIXEL_BURST = 16;
    localparam int LINE_BYTES  = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GATHER = 2'd1,
        ST_ISSUE  = 2'd2
    } burst_state_e;

    // Each pixel lane covers two bytes, so every mask bit enables a byte pair.
    function automatic logic [LINE_BYTES-1:0] expand_mask(input logic [PIXEL_BURST-1:0] mask);
        logic [LINE_BYTES-1:0] be;
        be = '0;
        for (int k = 0; k < PIXEL_BURST; k++) begin
            be[2*k +: 2] = {2{mask[k]}};
        end
        return be;
    endfunction

endpackage

// File: rtl/gpu_lane_pick.sv
// Lowest-set-bit encoder: picks the next pixel lane still waiting for data.
module gpu_lane_pick (
    input  logic [15:0] req_i,
    output logic [3:0]  index_o,
    output logic [15:0] onehot_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index_o  = '0;
        onehot_o = '0;
        for (int k = 15; k >= 0; k--) begin
            if (req_i[k]) begin
                index_o  = 4'(k);
                onehot_o = 16'(1) << k;
            end
        end
    end

endmodule

// File: rtl/gpu_mem_burst_writer.sv
// Merges address-generator beats with a pixel stream into masked 256-bit VRAM line writes.
module gpu_mem_burst_writer #(
    parameter int PIXEL_BURST = 16,
    parameter int ADDR_W      = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     gen_valid_i,
    input  logic [ADDR_W-1:0]        gen_addr_i,
    input  logic [PIXEL_BURST-1:0]   gen_mask_i,
    input  logic                     gen_last_i,
    output logic                     gen_accept_o,
    input  logic                     pix_valid_i,
    input  logic [15:0]              pix_data_i,
    output logic                     pix_ready_o,
    input  logic                     set_mask_i,
    input  logic                     abort_i,
    output logic                     mem_valid_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [PIXEL_BURST*16-1:0] mem_data_o,
    output logic [PIXEL_BURST*2-1:0] mem_be_o,
    input  logic                     mem_ready_i,
    output logic                     done_o
);
    import gpu_mem_pkg::*;

    burst_state_e             state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [PIXEL_BURST-1:0]   rem_q, rem_d;
    logic [PIXEL_BURST*16-1:0] data_q, data_d;
    logic [PIXEL_BURST*2-1:0] be_q, be_d;
    logic                     last_q, last_d;
    logic                     done_q, done_d;
    logic                     abort_seen_q, abort_seen_d;

    logic [3:0]               lane_idx;
    logic [15:0]              lane_onehot;
    logic [PIXEL_BURST-1:0]   rem_next;

    gpu_lane_pick u_lane_pick (
        .req_i    (rem_q),
        .index_o  (lane_idx),
        .onehot_o (lane_onehot)
    );

    assign rem_next = rem_q & ~lane_onehot;

    // Handshake outputs come from registered state only; reset also forces accept low.
    assign gen_accept_o = (state_q == ST_IDLE) && rst_n_i;
    assign pix_ready_o  = (state_q == ST_GATHER);
    assign mem_valid_o  = (state_q == ST_ISSUE);
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = data_q;
    assign mem_be_o     = be_q;
    assign done_o       = done_q;

    // Next-state logic: accept a beat, fill lanes in ascending order, then hold the write until taken.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        data_d       = data_q;
        be_d         = be_q;
        last_d       = last_q;
        done_d       = 1'b0;
        abort_seen_d = abort_seen_q;
        case (state_q)
            ST_IDLE: begin
                abort_seen_d = 1'b0;
                if (gen_valid_i) begin
                    addr_d = gen_addr_i;
                    rem_d  = gen_mask_i;
                    data_d = '0;
                    be_d   = expand_mask(gen_mask_i);
                    last_d = gen_last_i;
                    if (gen_mask_i != '0) begin
                        state_d = ST_GATHER;
                    end else begin
                        done_d = gen_last_i;
                    end
                end
            end
            ST_GATHER: begin
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (pix_valid_i) begin
                    data_d[16*lane_idx +: 16] = pix_data_i | {set_mask_i, 15'b0};
                    rem_d = rem_next;
                    if (rem_next == '0) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (abort_i) begin
                    abort_seen_d = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d = ST_IDLE;
                    done_d  = last_q && !abort_seen_q && !abort_i;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            data_q       <= '0;
            be_q         <= '0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            abort_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            data_q       <= data_d;
            be_q         <= be_d;
            last_q       <= last_d;
            done_q       <= done_d;
            abort_seen_q <= abort_seen_d;
        end
    end

endmodule
